// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants: FSM states, field widths and codeword bit positions.
// Positions are 1-based; code vectors hold position p at index p-1.
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DECODE  = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  localparam int CODE_LEN = 7;
  localparam int DATA_LEN = 4;
  localparam int SYN_W    = 3;

  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

endpackage

// File: rtl/hamming_decoder_serial_if.sv
// Serial code-bit input handshake and decoded-bit output bundle for the decoder.
interface hamming_decoder_serial_if;
  import hamming_pkg::*;

  logic             write;
  logic             data_in;
  logic             in_ready;
  logic             out_valid;
  logic             data_out;
  logic             corrected;
  logic [SYN_W-1:0] syndrome;

  modport master (
    output write,
    output data_in,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  corrected,
    input  syndrome
  );

  modport slave (
    input  write,
    input  data_in,
    output in_ready,
    output out_valid,
    output data_out,
    output corrected,
    output syndrome
  );
endinterface

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
// The syndrome value is the 1-based position of the bit to flip; zero means clean.
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CODE_LEN-1:0] code,
  output logic [CODE_LEN-1:0] fixed,
  output logic [SYN_W-1:0]    syndrome
);

  logic s1;
  logic s2;
  logic s4;

  assign s1 = code[POS_P1-1] ^ code[POS_D1-1] ^ code[POS_D2-1] ^ code[POS_D4-1];
  assign s2 = code[POS_P2-1] ^ code[POS_D1-1] ^ code[POS_D3-1] ^ code[POS_D4-1];
  assign s4 = code[POS_P4-1] ^ code[POS_D2-1] ^ code[POS_D3-1] ^ code[POS_D4-1];

  assign syndrome = {s4, s2, s1};

  genvar gi;
  generate
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_fix
      assign fixed[gi] = code[gi] ^ (syndrome == SYN_W'(gi + 1));
    end
  endgenerate

endmodule

// File: rtl/hamming_decoder_serial.sv
// Serial Hamming(7,4) decoder: collects 7 code bits, corrects one error,
// then streams d1..d4 over four out_valid cycles.
module hamming_decoder_serial
  import hamming_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  hamming_decoder_serial_if.slave   bus
);

  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] DECODE  = ST_DECODE;
  localparam logic [1:0] OUT     = ST_OUT;

  logic [1:0]          state_reg;
  logic [2:0]          bit_cnt_reg;
  logic [CODE_LEN-1:0] code_reg;
  logic [DATA_LEN-1:0] out_shift_reg;
  logic [1:0]          out_cnt_reg;
  logic                out_valid_reg;
  logic                corrected_reg;
  logic [SYN_W-1:0]    syndrome_reg;

  logic [CODE_LEN-1:0] fixed;
  logic [SYN_W-1:0]    syndrome_calc;
  logic [DATA_LEN-1:0] data_word;
  logic                in_ready;
  logic                accept;

  hamming74_correct u_correct (
    .code     (code_reg),
    .fixed    (fixed),
    .syndrome (syndrome_calc)
  );

  assign data_word = {fixed[POS_D4-1], fixed[POS_D3-1], fixed[POS_D2-1], fixed[POS_D1-1]};

  assign in_ready = (state_reg == COLLECT);
  assign accept   = bus.write && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= COLLECT;
      bit_cnt_reg   <= '0;
      code_reg      <= '0;
      out_shift_reg <= '0;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      corrected_reg <= 1'b0;
      syndrome_reg  <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          // First-received bit ends up at index 0 after seven shifts.
          if (accept) begin
            code_reg <= {bus.data_in, code_reg[CODE_LEN-1:1]};
            if (bit_cnt_reg == 3'd6) begin
              bit_cnt_reg <= '0;
              state_reg   <= DECODE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        DECODE: begin
          syndrome_reg  <= syndrome_calc;
          corrected_reg <= (syndrome_calc != '0);
          out_shift_reg <= data_word;
          out_valid_reg <= 1'b1;
          out_cnt_reg   <= '0;
          state_reg     <= OUT;
        end
        OUT: begin
          // Shifting zeros in leaves data_out low once the frame is done.
          out_shift_reg <= out_shift_reg >> 1;
          if (out_cnt_reg == 2'd3) begin
            out_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            corrected_reg <= 1'b0;
            syndrome_reg  <= '0;
            bit_cnt_reg   <= '0;
            state_reg     <= COLLECT;
          end else begin
            out_cnt_reg <= out_cnt_reg + 2'd1;
          end
        end
        default: begin
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.data_out  = out_shift_reg[0];
  assign bus.corrected = corrected_reg;
  assign bus.syndrome  = syndrome_reg;

endmodule

// File: tb/tb_hamming_decoder_serial.sv
// Directed bench for the serial Hamming(7,4) decoder with an expected-output scoreboard.
module tb_hamming_decoder_serial;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic       d;
    logic       c;
    logic [2:0] s;
  } exp_t;

  exp_t sb[$];

  hamming_decoder_serial_if bus ();

  hamming_decoder_serial dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  8'(bus.in_ready),  8'd1);
    chk({tag, "_out_valid"}, 8'(bus.out_valid), 8'd0);
    chk({tag, "_data_out"},  8'(bus.data_out),  8'd0);
    chk({tag, "_corrected"}, 8'(bus.corrected), 8'd0);
    chk({tag, "_syndrome"},  8'(bus.syndrome),  8'd0);
  endtask

  // Bit positions: frame[p-1] holds codeword position p.
  task automatic expect_frame(input logic [3:0] data, input logic c, input logic [2:0] s);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = data[i];
      e.c = c;
      e.s = s;
      sb.push_back(e);
    end
  endtask

  task automatic send_bit(input logic b);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 8'(bus.in_ready), 8'd1);
    bus.write   = 1'b1;
    bus.data_in = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] frame, input int gap_after);
    for (int i = 0; i < 7; i++) begin
      if (gap_after != 0 && i == gap_after) begin
        bus.write = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          chk("gap_in_ready", 8'(bus.in_ready), 8'd1);
        end
      end
      send_bit(frame[i]);
    end
  endtask

  // Called at the negedge right after the 7th bit was accepted.
  task automatic check_frame(input bit hold);
    if (hold) bus.data_in = 1'b1;
    else      bus.write   = 1'b0;
    chk("decode_in_ready",  8'(bus.in_ready),  8'd0);
    chk("decode_out_valid", 8'(bus.out_valid), 8'd0);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      @(negedge clk);
      if (hold) bus.data_in = ~bus.data_in;
      chk("sb_nonempty", 8'(sb.size() > 0), 8'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("out[%0d] data_out=%0b corrected=%0b syndrome=%0d (want %0b %0b %0d)",
                 k, bus.data_out, bus.corrected, bus.syndrome, e.d, e.c, e.s);
        chk("out_valid", 8'(bus.out_valid), 8'd1);
        chk("out_in_ready", 8'(bus.in_ready), 8'd0);
        chk("data_out", 8'(bus.data_out), 8'(e.d));
        chk("corrected", 8'(bus.corrected), 8'(e.c));
        chk("syndrome", 8'(bus.syndrome), 8'(e.s));
      end
    end
    @(negedge clk);
    bus.write = 1'b0;
    chk_idle("post_out");
  endtask

  initial begin
    rst         = 1'b1;
    bus.write   = 1'b0;
    bus.data_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean frame
    expect_frame(4'b1101, 1'b0, 3'd0);
    send_frame(7'b1100110, 0);
    check_frame(1'b0);

    // Data error at position 5
    expect_frame(4'b1101, 1'b1, 3'd5);
    send_frame(7'b1110110, 0);
    check_frame(1'b0);

    // Parity error at position 1
    expect_frame(4'b1101, 1'b1, 3'd1);
    send_frame(7'b1100111, 0);
    check_frame(1'b0);

    // Idle gap between bits 3 and 4, write held high through DECODE/OUT
    expect_frame(4'b1101, 1'b0, 3'd0);
    send_frame(7'b1100110, 3);
    check_frame(1'b1);

    // Follow-up frame shows nothing was captured during DECODE/OUT
    expect_frame(4'b1101, 1'b1, 3'd1);
    send_frame(7'b1100111, 0);
    check_frame(1'b0);

    // Reset after 4 accepted bits, with write asserted on the reset edge
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst         = 1'b1;
    bus.write   = 1'b1;
    bus.data_in = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    rst       = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");
    expect_frame(4'b1101, 1'b1, 3'd5);
    send_frame(7'b1110110, 0);
    check_frame(1'b0);

    // Back-to-back frames
    expect_frame(4'b1101, 1'b0, 3'd0);
    send_frame(7'b1100110, 0);
    check_frame(1'b0);
    expect_frame(4'b1101, 1'b1, 3'd5);
    send_frame(7'b1110110, 0);
    check_frame(1'b0);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_decoder_serial.md
HAMMING_DECODER_SERIAL -- requirements
Module: hamming_decoder_serial

Interface
REQ-001 Parameters SHALL be: none; codeword fixed at Hamming(7,4).
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write  input  1  data_in holds a valid code bit this cycle.
REQ-006 data_in  input  1  serial codeword bit, position 1 first, position 7 last.
REQ-007 in_ready  output  1  block accepts a code bit this cycle.
REQ-008 out_valid  output  1  data_out holds a valid decoded data bit.
REQ-009 data_out  output  1  serial decoded data bit: d1, d2, d3, d4.
REQ-010 corrected  output  1  nonzero syndrome on current frame; held while out_valid.
REQ-011 syndrome  output  3  {s4,s2,s1} of current frame; held while out_valid.

Function
REQ-012 Codeword positions 1..7 SHALL be p1, p2, d1, p4, d2, d3, d4.
REQ-013 A bit SHALL be accepted only on an edge where write=1 and in_ready=1; write with in_ready=0 is ignored.
REQ-014 Idle cycles (write=0) between accepted bits SHALL be allowed, with no timeout.
REQ-015 States SHALL be COLLECT, DECODE and OUT.
REQ-016 COLLECT SHALL assert in_ready, count accepted bits 0..6, and move to DECODE on the edge that accepts bit 7.
REQ-017 DECODE SHALL last one cycle with in_ready=0.
REQ-018 On the DECODE-exit edge the block SHALL register the following and enter OUT:
- syndrome: s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7;
- corrected = (syndrome != 0);
- corrected codeword: bit at position syndrome inverted when syndrome != 0.
REQ-019 OUT SHALL last exactly 4 cycles: out_valid=1; data_out = d1, d2, d3, d4 on consecutive cycles; in_ready=0.
REQ-020 On the edge ending OUT the block SHALL set out_valid=0, in_ready=1, corrected=0, syndrome=0 and bit count=0, and enter COLLECT.
REQ-021 Latency: 7th bit accepted at edge E -> out_valid and d1 from edge E+1 -> d4 at E+4 -> in_ready high from E+5.
REQ-022 Double-bit errors are undetectable and SHALL be miscorrected per the syndrome; no extra flag.
REQ-023 There SHALL be no backpressure on output; the downstream sink samples every out_valid cycle.

Reset
REQ-024 Reset SHALL apply on the next rising edge and produce:
- state COLLECT, bit count 0, shift register 0;
- in_ready=1;
- out_valid=0, data_out=0, corrected=0, syndrome=0.
REQ-025 Reset in any state, including mid-COLLECT or mid-OUT, SHALL discard the partial frame; the next accepted bit is position 1.
REQ-026 Reset SHALL take priority over write on the same edge.

Structure
REQ-027 Shared package hamming_pkg SHALL hold:
- state enum;
- codeword length 7, data length 4, syndrome width 3;
- position constants for p1/p2/p4/d1..d4.
REQ-028 Combinational syndrome computation and single-bit correction SHALL live in sub-module hamming74_correct: 7-bit in; 7-bit corrected out; 3-bit syndrome out.
REQ-029 Top level SHALL hold the input shift register, bit counter, FSM and output shift register.

Verification
REQ-030 Clean frame: bits 0,1,1,0,0,1,1 with write=1 back-to-back.
- out_valid for 4 cycles; data_out 1,0,1,1.
- corrected=0, syndrome=0.
REQ-031 Data error: bits 0,1,1,0,1,1,1 (position 5 flipped).
- data_out 1,0,1,1; corrected=1; syndrome=5.
REQ-032 Parity error: bits 1,1,1,0,0,1,1 (position 1 flipped).
- data_out 1,0,1,1; corrected=1; syndrome=1.
REQ-033 Gaps and blocked writes: clean frame with write=0 for 3 cycles between bits 3 and 4, plus write=1 held through DECODE/OUT.
- Output identical to REQ-030.
- Writes during DECODE/OUT are not captured.
- in_ready rises exactly 5 cycles after the 7th bit is accepted.
REQ-034 Reset mid-frame: reset after 4 accepted bits, then the REQ-031 frame.
- Decoded as REQ-031.
- All outputs at reset values during and immediately after reset.
REQ-035 Back-to-back frames: REQ-030 then REQ-031 frames, each sent as soon as in_ready=1.
- Two 4-cycle out_valid windows with the correct per-frame corrected/syndrome values.
